// File: rtl/sparq_int_pkg.sv
// rtl/sparq_int_pkg.sv - shared types and saturation helpers for integer reduction stages
package sparq_int_pkg;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} acc_state_e;

    // Largest positive value representable in a w-bit two's-complement word
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a w-bit two's-complement word
    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/int_accumulator_if.sv
// rtl/int_accumulator_if.sv - input beat stream and result handshake bundle
interface int_accumulator_if #(
    parameter int W_IN  = 17,
    parameter int W_ACC = 32,
    parameter int W_CNT = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W_IN-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W_ACC-1:0] out_data;
    logic [W_CNT-1:0] out_count;
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
endinterface

// File: rtl/sat_add.sv
// rtl/sat_add.sv - combinational W-bit signed saturating adder with overflow flag
module sat_add
    import sparq_int_pkg::*;
#(
    parameter int W = 32
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] y,
    output logic                ovf
);
    localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
    localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

    logic [W:0] sum;

    // One guard bit: the true sum never overflows W+1 bits
    assign sum = {a[W-1], a} + {b[W-1], b};

    // Guard and sign bits disagree only when the result left the W-bit range
    always_comb begin
        y   = sum[W-1:0];
        ovf = 1'b0;
        if (sum[W] != sum[W-1]) begin
            ovf = 1'b1;
            y   = sum[W] ? MIN_V : MAX_V;
        end
    end
endmodule

// File: rtl/int_accumulator.sv
// rtl/int_accumulator.sv - per-group saturating accumulator of signed sums with registered result
module int_accumulator
    import sparq_int_pkg::*;
#(
    parameter int W_IN  = 17,
    parameter int W_ACC = 32,
    parameter int W_CNT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    int_accumulator_if.slave  bus
);
    acc_state_e state, state_n;

    logic signed [W_ACC-1:0] acc;
    logic [W_CNT-1:0]        cnt;
    logic                    ovf;

    logic signed [W_IN-1:0]  din;
    logic signed [W_ACC-1:0] ext;
    logic signed [W_ACC-1:0] add_a;
    logic signed [W_ACC-1:0] sum;
    logic                    add_ovf;
    logic                    accept;
    logic                    first;
    logic [W_CNT-1:0]        cnt_next;
    logic                    ovf_next;

    assign bus.in_ready = (state != HOLD) || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // Any beat accepted outside ACC opens a new group (in HOLD it implies the result was taken)
    assign first = (state != ACC);

    assign din   = bus.in_data;
    assign ext   = W_ACC'(din);
    assign add_a = first ? '0 : acc;

    sat_add #(.W(W_ACC)) u_sat_add (
        .a   (add_a),
        .b   (ext),
        .y   (sum),
        .ovf (add_ovf)
    );

    assign cnt_next = first ? W_CNT'(1) : ((&cnt) ? cnt : cnt + W_CNT'(1));
    assign ovf_next = first ? add_ovf : (ovf | add_ovf);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic; clr overrides everything
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = bus.in_last ? HOLD : ACC;
            ACC:  if (accept && bus.in_last) state_n = HOLD;
            HOLD: if (bus.out_ready) begin
                if (accept) state_n = bus.in_last ? HOLD : ACC;
                else        state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (clr) state_n = IDLE;
    end

    // Running total, beat count and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (clr) begin
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (accept) begin
                acc <= sum;
                cnt <= cnt_next;
                ovf <= ovf_next;
                if (bus.in_last) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= sum;
                    bus.out_count <= cnt_next;
                    bus.out_ovf   <= ovf_next;
                end
            end else if (state == HOLD && bus.out_ready) begin
                acc <= '0;
                cnt <= '0;
                ovf <= 1'b0;
            end
        end
    end
endmodule

// File: doc/int_accumulator.md
Name: int_accumulator

Overview:
- Downstream consumer of the signed integer adder stage: takes a stream of W_IN-bit signed sums and accumulates them into a W_ACC-bit saturating running total.
- Accumulation is per group; a group is a run of beats terminated by in_last.
- On group end, presents {total, beat count, overflow flag} on a registered valid/ready output.
- Used to reduce partial sums, e.g. dot-product lanes, before requantization.

Parameters:
- W_IN, 17, input sum width; matches adder output width (max operand width + 1).
- W_ACC, 32, accumulator and output width; must be >= W_IN.
- W_CNT, 8, beat counter width; max countable group length is 2^W_CNT - 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous.
- clr  input  1  synchronous abort; discards the current group and any pending output.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_data  input  W_IN  signed sum from the adder stage.
- in_last  input  1  marks the final beat of a group.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  W_ACC  signed saturated group total.
- out_count  output  W_CNT  beats in the group, saturating at all-ones.
- out_ovf  output  1  sticky flag: saturation occurred at least once in the group.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_count=0, out_ovf=0, accumulator=0, state=IDLE. in_ready=1 out of reset, because it is combinational from the state.
- FSM states are IDLE, ACC and HOLD.
- Beat acceptance: a beat is accepted when in_valid && in_ready. in_ready = (state!=HOLD) || out_ready.
- Accumulation arithmetic:
  - in_data is sign-extended to W_ACC bits.
  - sum = acc + ext(in_data), computed at W_ACC+1 bits.
  - If sum > 2^(W_ACC-1)-1, clamp to the max positive value and set ovf. If sum < -2^(W_ACC-1), clamp to the min negative value and set ovf.
- First beat of a group: acc = ext(in_data), count = 1, ovf = 0. This applies in IDLE, and in HOLD when the pending result is consumed in the same cycle.
- Subsequent beats: acc = sat(acc + ext(in_data)), count = count + 1 saturating at 2^W_CNT-1, ovf |= new saturation.
- Transitions:
  - IDLE: on an accepted beat, go to ACC; if in_last is set, go straight to HOLD.
  - ACC: stays in ACC until an accepted beat carries in_last, then goes to HOLD.
  - A one-beat group (in_last on the first beat) goes straight to HOLD with count = 1.
- Result registration on the accepted in_last beat:
  - out_data, out_count and out_ovf register the final (post-update) values; out_valid = 1 on the following cycle.
  - Latency from the last beat accepted to out_valid is 1 cycle.
- HOLD:
  - Outputs stay stable while out_valid && !out_ready.
  - When out_ready=1 with no accepted beat: out_valid drops to 0 next cycle; acc and count clear; next state is IDLE.
  - When out_ready=1 with an accepted beat in the same cycle: the result is consumed and the beat starts a new group (next state ACC, or HOLD again if in_last). This gives zero-bubble back-to-back groups.
- clr (highest priority after reset):
  - Next cycle: state=IDLE, acc=0, count=0, out_valid=0. out_data, out_count and out_ovf are left unchanged.
  - A beat presented in the same cycle as clr is dropped.
  - in_ready is not gated by clr.
- Reset mid-group: all state clears immediately. No partial result is ever emitted.
- Idle output: out_data is held at its last value while out_valid=0; downstream must qualify it with out_valid.
- No combinational path from in_data to any output. in_ready depends combinationally only on state and out_ready.

Decomposition:
- Package sparq_int_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACC, HOLD} acc_state_e;
  - functions sat_max(W) and sat_min(W) returning the signed extremes for a given width.
- One sub-module, sat_add: combinational W_ACC-bit signed saturating adder with an overflow output. It is reusable by other reduction stages.

Test Plan:
- Basic group: in_data 5, -3, 10 (last), out_ready=1 → out_valid for exactly 1 cycle with out_data=12, out_count=3, out_ovf=0, asserted 1 cycle after the last beat.
- Saturation with W_ACC=20 override: beats 65535 ×9 (last) → out_data=524287, out_count=9, out_ovf=1. Repeat with -65536 ×9 (last) → out_data=-524288, out_count=9, out_ovf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after a result of 7: out_data stays 7 and in_ready stays 0.
  - Then raise out_ready with in_valid=1, in_data=4, in_last=1 → next result is 4 with count=1, and no bubble cycle between the two out_valid periods.
- Single-beat groups streamed back-to-back: inputs 1, 2, 3, each with in_last, and out_ready=1 → results 1, 2, 3 on consecutive cycles, each with count=1.
- Abort:
  - clr asserted after beats 100, 200 (in_last not yet seen) → no out_valid. Following group 8 (last) → out_data=8, count=1.
  - rst_n dropped mid-group → outputs are 0 immediately, without waiting for a clock edge.
- Count saturation with W_CNT=3: 10 beats of 1 (last) → out_count=7, out_data=10.
